mmv_ram_data_bus_tester: RTL and testbench



---
 rtl/mmv_ram_db_pkg.sv | 28 ++
 rtl/mmv_ram_data_bus_tester.sv | 139 +++++++++++++
 tb/tb_mmv_ram_data_bus_tester.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmv_ram_db_pkg.sv
// Shared types and helpers for the RAM data-bus tester.
// FSM state encoding and the walking-ones/zeros pattern generator.
package mmv_ram_db_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    WAIT
  } state_t;

  localparam int unsigned PMAX = 64;

  // k < dw: walking one; otherwise walking zero at bit k-dw.
  // Caller keeps the low dw bits.
  function automatic logic [PMAX-1:0] pattern(
    input int unsigned k,
    input int unsigned dw
  );
    logic [PMAX-1:0] one;
    logic [PMAX-1:0] p;
    one = PMAX'(1);
    if (k < dw) p = one << k;
    else p = ~(one << (k - dw));
    return p;
  endfunction

endpackage

// File: rtl/mmv_ram_data_bus_tester.sv
// Data-bus BIST master: walking ones then walking zeros
// written to one address, read back and compared.
module mmv_ram_data_bus_tester
  import mmv_ram_db_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8,
  parameter logic [AWIDTH-1:0] TADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  output logic              ready,
  output logic              fault,
  output logic              done,
  output logic [AWIDTH-1:0] m_addr,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_rval,
  input  logic              m_busy
);

  localparam int N  = 2 * DWIDTH;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  state_t          state_q;
  state_t          state_nxt;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   k_nxt;

  logic [PMAX-1:0] pw_cur;
  logic [PMAX-1:0] pw_nxt;
  logic [DWIDTH-1:0] pat_cur;
  logic [DWIDTH-1:0] pat_nxt;

  logic              wreq_nxt;
  logic              rreq_nxt;
  logic [AWIDTH-1:0] addr_nxt;
  logic [DWIDTH-1:0] wdat_nxt;
  logic              fault_nxt;
  logic              done_nxt;
  logic              chk;

  // Expected data for the current and upcoming pattern index.
  always_comb begin
    pw_cur  = pattern(32'(k_q), DWIDTH);
    pw_nxt  = pattern(32'(k_nxt), DWIDTH);
    pat_cur = pw_cur[DWIDTH-1:0];
    pat_nxt = pw_nxt[DWIDTH-1:0];
  end

  // State and pattern index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_nxt;
      k_q     <= k_nxt;
    end
  end

  // Next state; clear overrides everything, including start.
  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    if (clear) begin
      state_nxt = IDLE;
      k_nxt     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_nxt = WRITE;
            k_nxt     = '0;
          end
        end
        WRITE: begin
          if (!m_busy) state_nxt = READ;
        end
        READ: begin
          if (!m_busy) state_nxt = WAIT;
        end
        WAIT: begin
          if (m_rval) begin
            if (k_q == KLAST) begin
              state_nxt = IDLE;
              k_nxt     = '0;
            end else begin
              state_nxt = WRITE;
              k_nxt     = k_q + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          k_nxt     = '0;
        end
      endcase
    end
  end

  // Registered outputs are derived from where the FSM is heading.
  always_comb begin
    wreq_nxt  = (state_nxt == WRITE);
    rreq_nxt  = (state_nxt == READ);
    addr_nxt  = (wreq_nxt || rreq_nxt) ? TADDR : '0;
    wdat_nxt  = wreq_nxt ? pat_nxt : '0;
    chk       = !clear && (state_q == WAIT) && m_rval;
    fault_nxt = chk && (m_rdat != pat_cur);
    done_nxt  = chk && (k_q == KLAST);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wreq <= 1'b0;
      m_rreq <= 1'b0;
      m_addr <= '0;
      m_wdat <= '0;
      fault  <= 1'b0;
      done   <= 1'b0;
    end else begin
      m_wreq <= wreq_nxt;
      m_rreq <= rreq_nxt;
      m_addr <= addr_nxt;
      m_wdat <= wdat_nxt;
      fault  <= fault_nxt;
      done   <= done_nxt;
    end
  end

  assign ready = (state_q == IDLE);

endmodule

// File: tb/tb_mmv_ram_data_bus_tester.sv
// Bench for the RAM data-bus tester with an inline
// memory slave, stuck-at injection and busy stalls.
module tb_mmv_ram_data_bus_tester;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int N       = 2 * DW;
  localparam int RDDELAY = 16;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          start;
  logic          ready;
  logic          fault;
  logic          done;
  logic [AW-1:0] m_addr;
  logic          m_wreq;
  logic [DW-1:0] m_wdat;
  logic          m_rreq;
  logic [DW-1:0] m_rdat;
  logic          m_rval;
  logic          m_busy;

  mmv_ram_data_bus_tester #(
    .AWIDTH(AW),
    .DWIDTH(DW),
    .TADDR (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .start (start),
    .ready (ready),
    .fault (fault),
    .done  (done),
    .m_addr(m_addr),
    .m_wreq(m_wreq),
    .m_wdat(m_wdat),
    .m_rreq(m_rreq),
    .m_rdat(m_rdat),
    .m_rval(m_rval),
    .m_busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] sa0;
    logic [7:0] sa1;
    bit         busy;
    int         faults;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_w[$];
  logic [7:0] exp_r[$];
  logic [7:0] sa0, sa1;
  bit         busy_rand;
  bit         sb_en;
  bit         rd_pend;
  int         rd_cnt;
  logic [7:0] rd_addr;
  bit         fault_pend;
  logic       exp_fault;
  logic       exp_done;
  bit         hold_chk;
  logic [1:0] hold_req;
  logic [7:0] hold_a;
  logic [7:0] hold_d;
  int         n_fault;
  int         n_done;

  function automatic logic [7:0] pat(input int k);
    logic [7:0] one;
    one = 8'h01;
    if (k < DW) return one << k;
    return ~(one << (k - DW));
  endfunction

  function void chk(input string nm, input logic [31:0] act,
                    input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endfunction

  // Slave model plus scoreboard, acting between rising edges.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      rd_pend    = 0;
      fault_pend = 0;
      hold_chk   = 0;
      m_rval     = 1'b0;
      m_busy     = 1'b0;
    end else begin
      if (fault) n_fault++;
      if (done) n_done++;
      if (fault_pend) begin
        fault_pend = 0;
        chk("fault", fault, exp_fault);
        chk("done", done, exp_done);
      end
      if (hold_chk) begin
        hold_chk = 0;
        chk("hold_req", {m_wreq, m_rreq}, hold_req);
        chk("hold_addr", m_addr, hold_a);
        chk("hold_wdat", m_wdat, hold_d);
      end
      m_rval = 1'b0;
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          rd_pend = 0;
          m_rval  = 1'b1;
          m_rdat  = (mem[rd_addr] & ~sa0) | sa1;
          if (sb_en) begin
            if (exp_r.size() == 0) begin
              chk("rd_extra", 1, 0);
            end else begin
              e          = exp_r.pop_front();
              exp_fault  = (m_rdat != e);
              exp_done   = (exp_r.size() == 0) && (exp_w.size() == 0);
              fault_pend = 1;
            end
          end
        end
      end
      m_busy = busy_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      if (m_wreq && !m_busy) begin
        mem[m_addr] = m_wdat;
        if (sb_en) begin
          if (exp_w.size() == 0) begin
            chk("wr_extra", 1, 0);
          end else begin
            e = exp_w.pop_front();
            chk("wdat", m_wdat, e);
            chk("waddr", m_addr, 0);
            exp_r.push_back(e);
          end
        end
      end
      if (m_rreq && !m_busy) begin
        rd_pend = 1;
        rd_cnt  = RDDELAY;
        rd_addr = m_addr;
        if (sb_en) chk("raddr", m_addr, 0);
      end
      if (sb_en && m_busy && (m_wreq || m_rreq)) begin
        hold_chk = 1;
        hold_req = {m_wreq, m_rreq};
        hold_a   = m_addr;
        hold_d   = m_wdat;
      end
    end
  end

  task automatic run_test(input vec_t v);
    int cyc;
    int ready_bad;
    sa0 = v.sa0;
    sa1 = v.sa1;
    busy_rand = v.busy;
    exp_w.delete();
    exp_r.delete();
    for (int k = 0; k < N; k++) exp_w.push_back(pat(k));
    sb_en = 1;
    @(negedge clk);
    n_fault = 0;
    n_done  = 0;
    chk({v.name, "_ready_idle"}, ready, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, "_start_ready"}, ready, 0);
    chk({v.name, "_start_wreq"}, m_wreq, 1);
    cyc = 0;
    ready_bad = 0;
    while (!done && cyc < 4000) begin
      if (ready) ready_bad++;
      start = (v.busy && cyc == 5);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 4000) chk({v.name, "_timeout"}, 0, 1);
    chk({v.name, "_ready_low"}, ready_bad, 0);
    chk({v.name, "_ready_at_done"}, ready, 1);
    repeat (5) @(negedge clk);
    chk({v.name, "_faults"}, n_fault, v.faults);
    chk({v.name, "_dones"}, n_done, 1);
    chk({v.name, "_wr_left"}, exp_w.size(), 0);
    chk({v.name, "_rd_left"}, exp_r.size(), 0);
    busy_rand = 0;
  endtask

  vec_t vecs[4];
  int   spur;
  int   cyc;

  initial begin
    vecs[0] = '{"nominal", 8'h00, 8'h00, 1'b0, 0};
    vecs[1] = '{"sa0_b3",  8'h08, 8'h00, 1'b0, 8};
    vecs[2] = '{"sa1_b0",  8'h00, 8'h01, 1'b0, 8};
    vecs[3] = '{"busy",    8'h00, 8'h00, 1'b1, 0};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    m_rdat = '0;
    m_rval = 1'b0;
    m_busy = 1'b0;
    sa0 = '0;
    sa1 = '0;
    busy_rand = 0;
    sb_en = 0;
    n_fault = 0;
    n_done = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_wreq", m_wreq, 0);
    chk("rst_rreq", m_rreq, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdat", m_wdat, 0);
    chk("rst_fault_done", {fault, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_test(vecs[i]);

    // clear while a read is in flight
    sb_en = 0;
    sa0 = 8'hFF;
    sa1 = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!rd_pend && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("clr_read_seen", rd_pend, 1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_ready", ready, 1);
    chk("clr_reqs", {m_wreq, m_rreq}, 0);
    spur = 0;
    repeat (RDDELAY + 4) begin
      @(negedge clk);
      if (fault || done) spur++;
    end
    chk("clr_no_pulse", spur, 0);
    chk("clr_still_idle", ready, 1);
    sa0 = 8'h00;
    run_test(vecs[0]);

    // asynchronous reset mid-test
    sb_en = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_reqs", {m_wreq, m_rreq}, 0);
    chk("arst_addr", m_addr, 0);
    chk("arst_wdat", m_wdat, 0);
    chk("arst_pulses", {fault, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_test(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
